text_line_sequencer: RTL and testbench

- Upstream stage of the character drawing block. Buffers a line of 8-bit character codes written by game logic (keyboard/word generator).
- On start, issues one character plot per buffered code to the character drawer. Each plot carries `address`, `x_input` and `y_input`, and the stage handshakes on the drawer's `ready_to_start_character`.
- Advances the cursor per character, with wrap to a new text row. Also supports an erase pass that replays the same positions with `enable_clear` asserted.

---
 rtl/text_pkg.sv | 26 ++
 rtl/char_buffer.sv | 54 +++++
 rtl/text_line_sequencer.sv | 142 ++++++++++++++
 tb/tb_text_line_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants and FSM encoding for the text line sequencer and the character drawer.
package text_pkg;

    localparam int SCREEN_W      = 320;
    localparam int MAX_CHARS_DEF = 16;
    localparam int CHAR_W_DEF    = 9;
    localparam int LINE_H_DEF    = 12;
    localparam int X_LIMIT_DEF   = SCREEN_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ADVANCE,
        S_FINISH
    } seq_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic [8:0] x;
        logic [8:0] y;
    } plot_t;

endpackage

// File: rtl/char_buffer.sv
// Write-indexed store for one line of character codes, random-access read by index.
// Latency: an accepted write is visible in char_count/rd_data on the next cycle.
// Backpressure: none; writes are dropped unless wr_allow is high and the buffer is not full.
module char_buffer
    import text_pkg::*;
#(
    parameter int MAX_CHARS = MAX_CHARS_DEF,
    localparam int AW = $clog2(MAX_CHARS),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_allow,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic [AW-1:0] rd_idx,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] char_count,
    output logic          full,
    output logic          overflow
);

    logic [7:0] mem [MAX_CHARS];
    logic       do_flush;
    logic       do_write;

    assign full     = (char_count == CW'(MAX_CHARS));
    assign do_flush = wr_allow && flush;
    // flush beats a same-cycle write, so the write is simply lost
    assign do_write = wr_allow && wr_en && !flush && !full;
    assign rd_data  = mem[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_count <= '0;
            overflow   <= 1'b0;
        end else if (do_flush) begin
            char_count <= '0;
            overflow   <= 1'b0;
        end else if (do_write) begin
            char_count <= char_count + CW'(1);
        end else if (wr_allow && wr_en && full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[char_count[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/text_line_sequencer.sv
// Replays a buffered line of character codes to the character drawer, advancing and wrapping the cursor.
// Latency: start to first plot pulse is two cycles after the start cycle with an idle drawer.
// Backpressure: each plot waits for char_ready high, then for its fall (accept) and rise (finished).
module text_line_sequencer
    import text_pkg::*;
#(
    parameter int MAX_CHARS = MAX_CHARS_DEF,
    parameter int CHAR_W    = CHAR_W_DEF,
    parameter int LINE_H    = LINE_H_DEF,
    parameter int X_LIMIT   = X_LIMIT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic                        buf_flush,
    input  logic                        start,
    input  logic                        erase,
    input  logic [8:0]                  x_origin,
    input  logic [8:0]                  y_origin,
    input  logic                        char_ready,
    output logic [7:0]                  address,
    output logic [8:0]                  x_input,
    output logic [8:0]                  y_input,
    output logic                        enable_character_plot,
    output logic                        enable_clear,
    output logic [$clog2(MAX_CHARS):0]  char_count,
    output logic                        full,
    output logic                        overflow,
    output logic                        busy,
    output logic                        done
);

    localparam int AW = $clog2(MAX_CHARS);
    localparam int CW = AW + 1;
    localparam logic [9:0] STEP_X   = 10'(CHAR_W);
    localparam logic [9:0] TWO_STEP = 10'(2 * CHAR_W);
    localparam logic [9:0] STEP_Y   = 10'(LINE_H);
    localparam logic [9:0] EDGE_X   = 10'(X_LIMIT);

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [9:0]    cur_x;
    logic [9:0]    cur_y;
    logic [9:0]    org_x;
    logic          mode;
    logic [CW-1:0] rd_idx;
    logic [7:0]    rd_data;
    plot_t         plot_q;

    char_buffer #(.MAX_CHARS(MAX_CHARS)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .wr_allow   (state == S_IDLE),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .flush      (buf_flush),
        .rd_idx     (rd_idx[AW-1:0]),
        .rd_data    (rd_data),
        .char_count (char_count),
        .full       (full),
        .overflow   (overflow)
    );

    assign address = plot_q.code;
    assign x_input = plot_q.x;
    assign y_input = plot_q.y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt             = state;
        enable_character_plot = 1'b0;
        done                  = (state == S_FINISH);
        busy                  = (state != S_IDLE) && (state != S_FINISH);
        enable_clear          = mode && busy;
        case (state)
            S_IDLE:      if (start) state_nxt = S_LOAD;
            S_LOAD:      state_nxt = (char_count == '0) ? S_FINISH : S_ISSUE;
            S_ISSUE: begin
                if (char_ready) begin
                    enable_character_plot = 1'b1;
                    state_nxt             = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK:  if (!char_ready) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (char_ready) state_nxt = S_ADVANCE;
            S_ADVANCE:   state_nxt = (rd_idx + CW'(1) == char_count) ? S_FINISH : S_LOAD;
            S_FINISH:    state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_x  <= '0;
            cur_y  <= '0;
            org_x  <= '0;
            mode   <= 1'b0;
            rd_idx <= '0;
            plot_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_x  <= {1'b0, x_origin};
                        org_x  <= {1'b0, x_origin};
                        cur_y  <= {1'b0, y_origin};
                        mode   <= erase;
                        rd_idx <= '0;
                    end
                end
                S_LOAD: begin
                    if (char_count != '0) begin
                        plot_q.code <= rd_data;
                        plot_q.x    <= cur_x[8:0];
                        plot_q.y    <= cur_y[8:0];
                    end
                end
                S_ADVANCE: begin
                    rd_idx <= rd_idx + CW'(1);
                    // wrap when the following character would cross the right edge
                    if (cur_x + TWO_STEP > EDGE_X) begin
                        cur_x <= org_x;
                        cur_y <= cur_y + STEP_Y;
                    end else begin
                        cur_x <= cur_x + STEP_X;
                    end
                end
                S_FINISH: mode <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_line_sequencer.sv
// Directed plus randomized bench for text_line_sequencer with a behavioural drawer and line-layout model.
module tb_text_line_sequencer;

    localparam int CHAR_W    = 9;
    localparam int LINE_H    = 12;
    localparam int X_LIMIT   = 320;
    localparam int MAX_CHARS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       buf_flush;
    logic       start;
    logic       erase;
    logic [8:0] x_origin;
    logic [8:0] y_origin;
    logic       char_ready;
    logic [7:0] address;
    logic [8:0] x_input;
    logic [8:0] y_input;
    logic       enable_character_plot;
    logic       enable_clear;
    logic [4:0] char_count;
    logic       full;
    logic       overflow;
    logic       busy;
    logic       done;

    text_line_sequencer dut (
        .clk                   (clk),
        .reset                 (reset),
        .wr_en                 (wr_en),
        .wr_data               (wr_data),
        .buf_flush             (buf_flush),
        .start                 (start),
        .erase                 (erase),
        .x_origin              (x_origin),
        .y_origin              (y_origin),
        .char_ready            (char_ready),
        .address               (address),
        .x_input               (x_input),
        .y_input               (y_input),
        .enable_character_plot (enable_character_plot),
        .enable_clear          (enable_clear),
        .char_count            (char_count),
        .full                  (full),
        .overflow              (overflow),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // drawer model: accepts a plot one cycle after the pulse, then stays busy busy_len cycles
    logic drv_rdy  = 1'b1;
    logic hold_low = 1'b0;
    logic ack_pend = 1'b0;
    int   busy_cnt = 0;
    int   busy_len = 5;
    assign char_ready = drv_rdy && !hold_low;

    logic [7:0] rec_addr[$];
    logic [8:0] rec_x[$];
    logic [8:0] rec_y[$];
    logic       rec_clr[$];
    int         rec_cyc[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         clr_bad  = 0;
    logic       tracking = 1'b0;
    logic       exp_mode = 1'b0;

    logic [7:0] mbuf[$];
    int         p_base, p_dbase, p_cbase, p_start_cyc, rel_cyc;
    logic [8:0] p_x0, p_y0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                drv_rdy = 1'b1; ack_pend = 1'b0; busy_cnt = 0; tracking = 1'b0;
            end else if (ack_pend) begin
                drv_rdy = 1'b0; ack_pend = 1'b0; busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) drv_rdy = 1'b1;
            end
            #1;
            if (reset === 1'b0) begin
                if (enable_character_plot === 1'b1) begin
                    rec_addr.push_back(address);
                    rec_x.push_back(x_input);
                    rec_y.push_back(y_input);
                    rec_clr.push_back(enable_clear);
                    rec_cyc.push_back(cyc);
                    ack_pend = 1'b1;
                    tracking = 1'b1;
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (enable_clear !== 1'b0) clr_bad++;
                    tracking = 1'b0;
                end else if (tracking && enable_clear !== exp_mode) begin
                    clr_bad++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_char(input logic [7:0] c);
        wr_en = 1'b1; wr_data = c;
        tick(1);
        wr_en = 1'b0;
        if (mbuf.size() < MAX_CHARS) mbuf.push_back(c);
    endtask

    task automatic do_flush();
        buf_flush = 1'b1;
        tick(1);
        buf_flush = 1'b0;
        mbuf.delete();
    endtask

    task automatic start_pass(input logic [8:0] x0, input logic [8:0] y0, input logic er);
        p_base = rec_addr.size(); p_dbase = done_cnt; p_cbase = clr_bad;
        p_x0 = x0; p_y0 = y0; exp_mode = er;
        x_origin = x0; y_origin = y0; erase = er; start = 1'b1;
        p_start_cyc = cyc + 1;
        tick(1);
        start = 1'b0; erase = 1'b0;
    endtask

    // Layout model: a row holds as many characters as fit after the origin (at least one);
    // character i sits at column i%cpr, row i/cpr, coordinates truncated to 9 bits.
    task automatic finish_pass(input string tag);
        int n, cpr, col, row;
        for (int i = 0; i < 3000 && done_cnt == p_dbase; i++) tick(1);
        tick(6);
        n   = mbuf.size();
        cpr = (int'(p_x0) + 2 * CHAR_W <= X_LIMIT) ? (X_LIMIT - int'(p_x0)) / CHAR_W : 1;
        check({tag, ".pulses"}, rec_addr.size() - p_base, n);
        check({tag, ".done"}, done_cnt - p_dbase, 1);
        for (int i = 0; i < n && p_base + i < rec_addr.size(); i++) begin
            col = i % cpr;
            row = i / cpr;
            check($sformatf("%s.addr%0d", tag, i), rec_addr[p_base + i], mbuf[i]);
            check($sformatf("%s.x%0d", tag, i), rec_x[p_base + i], (int'(p_x0) + col * CHAR_W) % 512);
            check($sformatf("%s.y%0d", tag, i), rec_y[p_base + i], (int'(p_y0) + row * LINE_H) % 512);
            check($sformatf("%s.clr%0d", tag, i), rec_clr[p_base + i], exp_mode);
        end
        check({tag, ".clear_level"}, clr_bad - p_cbase, 0);
        check({tag, ".idle_after"}, busy, 0);
    endtask

    initial begin
        logic [8:0] rx, ry;
        logic       rer;
        int         n;
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; buf_flush = 1'b0;
        start = 1'b0; erase = 1'b0; x_origin = '0; y_origin = '0;
        tick(3);
        reset = 1'b0;
        tick(2);
        check("rst.pos", {address, x_input, y_input}, 0);
        check("rst.flags", {enable_character_plot, enable_clear, char_count, full, overflow, busy, done}, 0);

        // "ABC" draw then erase over the same positions
        put_char(8'h41); put_char(8'h42); put_char(8'h43);
        check("abc.count", char_count, 3);
        busy_len = 5;
        start_pass(9'd10, 9'd20, 1'b0);
        finish_pass("abc");
        // start occupies cycle 0, first pulse lands in the ISSUE cycle two later
        check("abc.latency", rec_cyc[p_base] - p_start_cyc, 2);
        start_pass(9'd10, 9'd20, 1'b1);
        finish_pass("erase");
        check("erase.count_kept", char_count, 3);

        // wrap: 309 + 18 > 320 sends the third character to the next row
        do_flush();
        put_char(8'h61); put_char(8'h62); put_char(8'h63);
        start_pass(9'd300, 9'd40, 1'b0);
        finish_pass("wrap");

        // empty buffer: no plots, done two cycles after start
        do_flush();
        start_pass(9'd50, 9'd50, 1'b0);
        finish_pass("empty");
        check("empty.done_lat", done_cyc - p_start_cyc, 2);

        // overfill, then flush with a simultaneous write
        for (int i = 0; i < 17; i++) put_char(8'($urandom_range(0, 255)));
        check("full.count", char_count, 16);
        check("full.full", full, 1);
        check("full.overflow", overflow, 1);
        buf_flush = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
        tick(1);
        buf_flush = 1'b0; wr_en = 1'b0;
        mbuf.delete();
        check("flush.state", {char_count, full, overflow}, 0);

        // drawer held not-ready; writes, flush and start mid-pass are ignored
        for (int i = 0; i < 16; i++) put_char(8'($urandom_range(0, 255)));
        hold_low = 1'b1;
        start_pass(9'd0, 9'd100, 1'b0);
        tick(50);
        check("hold.no_pulse", rec_addr.size() - p_base, 0);
        check("hold.busy", busy, 1);
        wr_en = 1'b1; wr_data = 8'hAA; tick(1); wr_en = 1'b0;
        buf_flush = 1'b1; tick(1); buf_flush = 1'b0;
        start = 1'b1; erase = 1'b1; tick(1); start = 1'b0; erase = 1'b0;
        check("hold.count", char_count, 16);
        check("hold.overflow", overflow, 0);
        rel_cyc = cyc + 1;
        hold_low = 1'b0;
        finish_pass("hold");
        check("hold.after_release", rec_cyc[p_base] >= rel_cyc, 1);

        // randomized lines, each drawn then erased
        for (int k = 0; k < 6; k++) begin
            do_flush();
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) put_char(8'($urandom_range(0, 255)));
            busy_len = $urandom_range(1, 6);
            rx  = (k % 2 == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(250, 325));
            ry  = 9'($urandom_range(0, 511));
            rer = 1'($urandom_range(0, 1));
            start_pass(rx, ry, rer);
            finish_pass($sformatf("rnd%0d", k));
            start_pass(rx, ry, 1'b1);
            finish_pass($sformatf("rnd%0d_er", k));
        end

        // async reset while the second character is being drawn
        do_flush();
        for (int i = 0; i < 4; i++) put_char(8'h30 + 8'(i));
        busy_len = 5;
        start_pass(9'd20, 9'd30, 1'b1);
        for (int i = 0; i < 500 && rec_addr.size() < p_base + 2; i++) tick(1);
        tick(2);
        check("rst_mid.pre_busy", {busy, enable_clear}, 2'b11);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid.pos", {address, x_input, y_input}, 0);
        check("rst_mid.flags", {enable_character_plot, enable_clear, char_count, full, overflow, busy, done}, 0);
        tick(1);
        reset = 1'b0;
        mbuf.delete();
        tick(30);
        check("rst_mid.no_more_pulses", rec_addr.size() - p_base, 2);
        check("rst_mid.no_done", done_cnt - p_dbase, 0);
        check("rst_mid.count", char_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
